// File: rtl/evolved_circuit_tester_pkg.sv
// Shared types and the expected-output function for the evolved-circuit testers.
package evolved_circuit_tester_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_CHECK,
        S_FINISH
    } state_t;

    // Target function: odd parity of the applied vector, optionally inverted (XNOR target).
    function automatic logic expected_bit(input logic [31:0] vec, input logic inv);
        return (^vec) ^ inv;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, async active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/evolved_circuit_tester.sv
// Exhaustive sweep tester: applies every input vector, lets the netlist settle,
// samples its synchronized output several times and records mismatch/instability.
module evolved_circuit_tester
    import evolved_circuit_tester_pkg::*;
#(
    parameter int IN_WIDTH      = 3,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLES       = 4,
    parameter int EXPECT_INV    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [IN_WIDTH-1:0]      dut_in,
    input  logic                     dut_out,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [IN_WIDTH:0]        err_count,
    output logic [2**IN_WIDTH-1:0]   fail_mask,
    output logic [2**IN_WIDTH-1:0]   unstable_mask
);

    localparam int NVEC = 2**IN_WIDTH;
    localparam int SW   = $clog2(SETTLE_CYCLES + 1);
    localparam int MW   = $clog2(SAMPLES + 1);

    state_t              r_state,    w_state_nxt;
    logic [IN_WIDTH-1:0] r_dut_in,   w_dut_in_nxt;
    logic [SW-1:0]       r_settle,   w_settle_nxt;
    logic [MW-1:0]       r_samp,     w_samp_nxt;
    logic                r_mism,     w_mism_nxt;
    logic                r_unst,     w_unst_nxt;
    logic                r_first,    w_first_nxt;
    logic                r_pass,     w_pass_nxt;
    logic [IN_WIDTH:0]   r_err,      w_err_nxt;
    logic [NVEC-1:0]     r_fail,     w_fail_nxt;
    logic [NVEC-1:0]     r_umask,    w_umask_nxt;
    logic                w_sync;
    logic                w_exp;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (dut_out),
        .o_q   (w_sync)
    );

    assign w_exp = expected_bit(32'(r_dut_in), EXPECT_INV != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_dut_in <= '0;
            r_settle <= '0;
            r_samp   <= '0;
            r_mism   <= 1'b0;
            r_unst   <= 1'b0;
            r_first  <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_fail   <= '0;
            r_umask  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_dut_in <= w_dut_in_nxt;
            r_settle <= w_settle_nxt;
            r_samp   <= w_samp_nxt;
            r_mism   <= w_mism_nxt;
            r_unst   <= w_unst_nxt;
            r_first  <= w_first_nxt;
            r_pass   <= w_pass_nxt;
            r_err    <= w_err_nxt;
            r_fail   <= w_fail_nxt;
            r_umask  <= w_umask_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_dut_in_nxt = r_dut_in;
        w_settle_nxt = r_settle;
        w_samp_nxt   = r_samp;
        w_mism_nxt   = r_mism;
        w_unst_nxt   = r_unst;
        w_first_nxt  = r_first;
        w_pass_nxt   = r_pass;
        w_err_nxt    = r_err;
        w_fail_nxt   = r_fail;
        w_umask_nxt  = r_umask;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_err_nxt    = '0;
                    w_fail_nxt   = '0;
                    w_umask_nxt  = '0;
                    w_pass_nxt   = 1'b0;
                    w_dut_in_nxt = '0;
                    w_settle_nxt = '0;
                    w_samp_nxt   = '0;
                    w_mism_nxt   = 1'b0;
                    w_unst_nxt   = 1'b0;
                    w_state_nxt  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
                    w_samp_nxt  = '0;
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_settle_nxt = r_settle + SW'(1);
                end
            end
            S_SAMPLE: begin
                w_mism_nxt = r_mism | (w_sync != w_exp);
                // The first sample becomes the reference the rest are compared to.
                if (r_samp == '0) w_first_nxt = w_sync;
                else              w_unst_nxt  = r_unst | (w_sync != r_first);
                if (r_samp == MW'(SAMPLES - 1)) w_state_nxt = S_CHECK;
                else                            w_samp_nxt  = r_samp + MW'(1);
            end
            S_CHECK: begin
                w_fail_nxt[r_dut_in]  = r_mism;
                w_umask_nxt[r_dut_in] = r_unst;
                w_err_nxt             = r_err + {{IN_WIDTH{1'b0}}, r_mism};
                if (r_dut_in == {IN_WIDTH{1'b1}}) begin
                    // Verdict is ready the same cycle done is raised.
                    w_pass_nxt  = (w_fail_nxt == '0) && (w_umask_nxt == '0);
                    w_state_nxt = S_FINISH;
                end else begin
                    w_dut_in_nxt = r_dut_in + IN_WIDTH'(1);
                    w_settle_nxt = '0;
                    w_samp_nxt   = '0;
                    w_mism_nxt   = 1'b0;
                    w_unst_nxt   = 1'b0;
                    w_state_nxt  = S_SETTLE;
                end
            end
            S_FINISH: begin
                w_dut_in_nxt = '0;
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign dut_in        = r_dut_in;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_FINISH);
    assign pass          = r_pass;
    assign err_count     = r_err;
    assign fail_mask     = r_fail;
    assign unstable_mask = r_umask;

endmodule

// File: tb/tb_evolved_circuit_tester.sv
// Directed bench: behavioural DUT models feed the tester; expected sweep results
// are queued at start and compared when done is seen.
module tb_evolved_circuit_tester;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, start2 = 1'b0;
    logic [2:0] dut_in, dut_in2;
    logic       dut_out, dut_out2;
    logic       busy, done, pass, busy2, done2, pass2;
    logic [3:0] err_count, err_count2;
    logic [7:0] fail_mask, unstable_mask, fail_mask2, unstable_mask2;

    int checks = 0;
    int failures = 0;
    int mode = 0;

    typedef struct {
        logic [7:0] fm;
        logic [7:0] um;
        logic [3:0] ec;
        logic       ps;
    } res_t;
    res_t sb_q[$];

    always #5 clk = ~clk;

    evolved_circuit_tester dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_mask(fail_mask), .unstable_mask(unstable_mask)
    );

    evolved_circuit_tester #(.SETTLE_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dut_in(dut_in2), .dut_out(dut_out2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
        .fail_mask(fail_mask2), .unstable_mask(unstable_mask2)
    );

    // Behavioural netlists: ideal, inverted, stuck, oscillating, 4-clock delayed.
    logic       tog = 1'b0;
    logic [2:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
    logic [2:0] e1 = '0, e2 = '0, e3 = '0, e4 = '0;
    always @(posedge clk) begin
        tog <= ~tog;
        d1 <= dut_in;  d2 <= d1; d3 <= d2; d4 <= d3;
        e1 <= dut_in2; e2 <= e1; e3 <= e2; e4 <= e3;
    end
    always_comb begin
        case (mode)
            0:       dut_out = ^dut_in;
            1:       dut_out = ~^dut_in;
            2:       dut_out = 1'b0;
            3:       dut_out = tog;
            default: dut_out = ^d4;
        endcase
    end
    assign dut_out2 = ^e4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] fm, input logic [7:0] um,
                            input logic [3:0] ec, input logic ps);
        res_t r;
        r.fm = fm; r.um = um; r.ec = ec; r.ps = ps;
        sb_q.push_back(r);
    endtask

    // n = 1 is the clock cycle right after the start edge.
    task automatic do_sweep(input string tag, input bit inst, input int exp_lat, input int restart_at);
        int   n, ndone, lat;
        res_t e;
        @(negedge clk);
        if (inst) start2 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start2 = 1'b0;
        chk({tag, "_busy"}, inst ? busy2 : busy, 1);
        n = 1; ndone = 0; lat = 0;
        while (n <= exp_lat + 20) begin
            if (!inst) start = (n == restart_at);
            if (inst ? done2 : done) begin
                ndone++;
                if (lat == 0) lat = n;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_done_cnt"}, ndone, 1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_fail_mask"}, inst ? fail_mask2 : fail_mask, e.fm);
            chk({tag, "_unstable"}, inst ? unstable_mask2 : unstable_mask, e.um);
            chk({tag, "_err_count"}, inst ? err_count2 : err_count, e.ec);
            chk({tag, "_pass"}, inst ? pass2 : pass, e.ps);
        end
        chk({tag, "_idle"}, inst ? busy2 : busy, 0);
    endtask

    initial begin
        int k, nd;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dut_in", dut_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_fail", fail_mask, 0);
        chk("rst_unst", unstable_mask, 0);
        @(negedge clk);
        rst_n = 1'b1;

        mode = 0; push_exp(8'h00, 8'h00, 4'd0, 1'b1); do_sweep("xor", 0, 105, 0);
        mode = 1; push_exp(8'hFF, 8'h00, 4'd8, 1'b0); do_sweep("xnor", 0, 105, 0);
        mode = 2; push_exp(8'h96, 8'h00, 4'd4, 1'b0); do_sweep("stuck0", 0, 105, 0);
        mode = 3; push_exp(8'hFF, 8'hFF, 4'd8, 1'b0); do_sweep("toggle", 0, 105, 0);
        mode = 4; push_exp(8'h00, 8'h00, 4'd0, 1'b1); do_sweep("delay4", 0, 105, 0);
        // Short settle: first three samples still see the previous vector's parity.
        push_exp(8'hBA, 8'hBA, 4'd5, 1'b0); do_sweep("delay4_s3", 1, 65, 0);

        // Abort a sweep with reset during vector 3.
        mode = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        k = 0;
        while (dut_in != 3'd3 && k < 200) begin
            @(posedge clk); #1; k++;
        end
        chk("reach_vec3", dut_in, 3);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_dut_in", dut_in, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        chk("abort_fail", fail_mask, 0);
        chk("abort_err", err_count, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        chk("abort_no_done", nd, 0);

        // Second start mid-sweep must be ignored.
        push_exp(8'h00, 8'h00, 4'd0, 1'b1); do_sweep("restart", 0, 105, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
